// File: rtl/control_unit_pipe.sv
// Registered control decoder acting as the ID/EX pipeline register, with load-use stall, flush and illegal-opcode detection.
// Optional macro CU_PERF_CNT_EN adds saturating stall_count/flush_count outputs.
module control_unit_pipe #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned ALU_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ALU_W-1:0] out_alu_control,
  output logic [1:0]       out_imm_src,
  output logic             out_pc_src,
  output logic             out_mem_to_reg,
  output logic             out_mem_write,
  output logic             out_reg_write,
  output logic             out_alu_src,
  output logic [REG_W-1:0] out_rd,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic             hazard_stall,
  output logic             illegal_op
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
`endif
);

  logic [2:0]       cls;
  logic [2:0]       low;
  logic             legal;
  logic             uses_rs1;
  logic             uses_rs2;
  logic [ALU_W-1:0] d_alu;
  logic [1:0]       d_imm;
  logic             d_pc_src;
  logic             d_mem_to_reg;
  logic             d_mem_write;
  logic             d_reg_write;
  logic             d_alu_src;

  logic advance;
  logic hazard;
  logic load_en;
  logic accept;

  assign cls = opcode[5:3];
  assign low = opcode[2:0];

  always_comb begin
    legal        = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    d_alu        = '0;
    d_alu[4:0]   = {opcode[5:4], opcode[2:0]};
    d_imm        = 2'b00;
    d_pc_src     = 1'b0;
    d_mem_to_reg = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_alu_src    = 1'b0;
    case (cls)
      3'b000: begin
        legal       = low inside {[3'd1:3'd4]};
        d_reg_write = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = (low != 3'd4);
      end
      3'b001: begin
        legal       = low inside {[3'd1:3'd4]};
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        uses_rs1    = (low != 3'd4);
      end
      3'b010: begin
        legal       = low inside {[3'd1:3'd4]};
        d_reg_write = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = (low != 3'd4);
      end
      3'b011: begin
        legal       = low inside {[3'd1:3'd2]};
        d_imm       = 2'b01;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        uses_rs1    = 1'b1;
      end
      3'b101: begin
        legal        = low inside {[3'd1:3'd3]};
        d_imm        = 2'b10;
        d_alu_src    = 1'b1;
        d_reg_write  = (low != 3'd3);
        d_mem_to_reg = (low == 3'd1);
        d_mem_write  = (low == 3'd3);
        uses_rs1     = (low != 3'd2);
        uses_rs2     = (low == 3'd3);
      end
      3'b111: begin
        legal     = (low != 3'd7);
        d_imm     = 2'b11;
        d_alu_src = 1'b1;
        d_pc_src  = 1'b1;
      end
      default: ;
    endcase
    // An illegal opcode never stalls; it is consumed and dropped.
    if (!legal) begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign advance      = out_ready | ~out_valid;
  assign hazard       = out_valid & out_mem_to_reg & in_valid &
                        ((uses_rs1 & (out_rd == rs1)) | (uses_rs2 & (out_rd == rs2)));
  assign hazard_stall = hazard & ~flush;
  assign in_ready     = flush | (advance & ~hazard);
  assign load_en      = flush | advance;
  assign accept       = ~flush & advance & ~hazard & in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_alu_control <= '0;
      out_imm_src     <= '0;
      out_pc_src      <= 1'b0;
      out_mem_to_reg  <= 1'b0;
      out_mem_write   <= 1'b0;
      out_reg_write   <= 1'b0;
      out_alu_src     <= 1'b0;
      out_rd          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      illegal_op      <= 1'b0;
    end else begin
      // Every loaded slot that is not a legal accept is a zeroed bubble.
      if (load_en) begin
        if (accept && legal) begin
          out_valid       <= 1'b1;
          out_alu_control <= d_alu;
          out_imm_src     <= d_imm;
          out_pc_src      <= d_pc_src;
          out_mem_to_reg  <= d_mem_to_reg;
          out_mem_write   <= d_mem_write;
          out_reg_write   <= d_reg_write;
          out_alu_src     <= d_alu_src;
          out_rd          <= rd;
          out_rs1         <= rs1;
          out_rs2         <= rs2;
        end else begin
          out_valid       <= 1'b0;
          out_alu_control <= '0;
          out_imm_src     <= '0;
          out_pc_src      <= 1'b0;
          out_mem_to_reg  <= 1'b0;
          out_mem_write   <= 1'b0;
          out_reg_write   <= 1'b0;
          out_alu_src     <= 1'b0;
          out_rd          <= '0;
          out_rs1         <= '0;
          out_rs2         <= '0;
        end
      end
      if (accept && !legal) begin
        illegal_op <= 1'b1;
      end
    end
  end

`ifdef CU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard_stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (flush && in_valid && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: stimulus pushes expected EX entries, a monitor pops on each out_valid&out_ready transfer.
module tb_control_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [3:0] rd, rs1, rs2;
  logic       flush;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_alu_control;
  logic [1:0] out_imm_src;
  logic       out_pc_src, out_mem_to_reg, out_mem_write, out_reg_write, out_alu_src;
  logic [3:0] out_rd, out_rs1, out_rs2;
  logic       hazard_stall;
  logic       illegal_op;
`ifdef CU_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  control_unit_pipe #(.REG_W(4), .ALU_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_alu_control(out_alu_control), .out_imm_src(out_imm_src),
    .out_pc_src(out_pc_src), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_alu_src(out_alu_src), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .hazard_stall(hazard_stall), .illegal_op(illegal_op)
`ifdef CU_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] e(input logic [4:0] alu, input logic [1:0] imm,
                                    input logic pc, input logic mtr, input logic mw,
                                    input logic rw, input logic asrc,
                                    input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    return {alu, imm, pc, mtr, mw, rw, asrc, d, s1, s2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2);
    in_valid = v; opcode = op; rd = d; rs1 = s1; rs2 = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #2;
  endtask

  // Monitor: a transfer happens at the next posedge when out_valid & out_ready.
  initial begin
    logic [23:0] act;
    logic [23:0] expv;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        act = {out_alu_control, out_imm_src, out_pc_src, out_mem_to_reg, out_mem_write,
               out_reg_write, out_alu_src, out_rd, out_rs1, out_rs2};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h expected=none", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            errors++;
            $display("FAIL ex_entry actual=%h expected=%h", act, expv);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 6'o00, 4'd0, 4'd0, 4'd0);
    #2;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_fields", 32'({out_alu_control, out_imm_src, out_reg_write, out_alu_src, out_rd}), 0);
    chk("reset_illegal", 32'(illegal_op), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ADD
    drive(1'b1, 6'b000001, 4'd3, 4'd1, 4'd2);
    peek();
    chk("add_in_ready", 32'(in_ready), 1);
    exp_q.push_back(e(5'b00001, 2'b00, 0, 0, 0, 1, 0, 4'd3, 4'd1, 4'd2));
    tick();
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    chk("add_out_valid", 32'(out_valid), 1);

    // LDR then dependent SUB: one stall cycle
    drive(1'b1, 6'b101001, 4'd5, 4'd0, 4'd0);
    exp_q.push_back(e(5'b10001, 2'b10, 0, 1, 0, 1, 1, 4'd5, 4'd0, 4'd0));
    tick();
    drive(1'b1, 6'b000010, 4'd6, 4'd1, 4'd5);
    peek();
    chk("ldr_use_stall", 32'(hazard_stall), 1);
    chk("ldr_use_in_ready", 32'(in_ready), 0);
    tick();
    peek();
    chk("bubble_valid", 32'(out_valid), 0);
    chk("after_stall_hazard", 32'(hazard_stall), 0);
    chk("after_stall_in_ready", 32'(in_ready), 1);
    exp_q.push_back(e(5'b00010, 2'b00, 0, 0, 0, 1, 0, 4'd6, 4'd1, 4'd5));
    tick();

    // STR
    drive(1'b1, 6'b101011, 4'd0, 4'd2, 4'd3);
    exp_q.push_back(e(5'b10011, 2'b10, 0, 0, 1, 0, 1, 4'd0, 4'd2, 4'd3));
    tick();

    // ANDI held under backpressure, ORI waits
    drive(1'b1, 6'b011001, 4'd7, 4'd4, 4'd0);
    exp_q.push_back(e(5'b01001, 2'b01, 0, 0, 0, 1, 1, 4'd7, 4'd4, 4'd0));
    tick();
    out_ready = 1'b0;
    drive(1'b1, 6'b011010, 4'd8, 4'd9, 4'd0);
    peek();
    chk("backpressure_in_ready", 32'(in_ready), 0);
    tick(); tick();
    chk("andi_held_alu", 32'(out_alu_control), 32'b01001);
    chk("andi_held_rd", 32'(out_rd), 7);
    out_ready = 1'b1;
    peek();
    chk("release_in_ready", 32'(in_ready), 1);
    exp_q.push_back(e(5'b01010, 2'b01, 0, 0, 0, 1, 1, 4'd8, 4'd9, 4'd0));
    tick();
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    tick();

    // Flush with JEQ at input while a MUL is held under backpressure
    drive(1'b1, 6'b000011, 4'd1, 4'd2, 4'd3);
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 6'b111001, 4'd0, 4'd0, 4'd0);
    peek();
    chk("flush_in_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0;
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    chk("flush_bubble", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();

    // Stall while held, then flush overrides the stall
    drive(1'b1, 6'b101001, 4'd9, 4'd0, 4'd0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 4'd1, 4'd9, 4'd0);
    peek();
    chk("held_stall", 32'(hazard_stall), 1);
    chk("held_stall_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b1;
    peek();
    chk("flush_masks_stall", 32'(hazard_stall), 0);
    chk("flush_masks_in_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    chk("flush_kills_ldr", 32'(out_valid), 0);
    tick();

    // Source-usage corner cases and remaining formats
    drive(1'b1, 6'b101001, 4'd4, 4'd1, 4'd0);
    exp_q.push_back(e(5'b10001, 2'b10, 0, 1, 0, 1, 1, 4'd4, 4'd1, 4'd0));
    tick();
    drive(1'b1, 6'b001100, 4'd2, 4'd4, 4'd4);
    peek();
    chk("movi_no_hazard", 32'(hazard_stall), 0);
    exp_q.push_back(e(5'b00100, 2'b00, 0, 0, 0, 1, 1, 4'd2, 4'd4, 4'd4));
    tick();
    drive(1'b1, 6'b101010, 4'd3, 4'd0, 4'd0);
    exp_q.push_back(e(5'b10010, 2'b10, 0, 0, 0, 1, 1, 4'd3, 4'd0, 4'd0));
    tick();
    drive(1'b1, 6'b010100, 4'd10, 4'd0, 4'd4);
    exp_q.push_back(e(5'b01100, 2'b00, 0, 0, 0, 1, 0, 4'd10, 4'd0, 4'd4));
    tick();
    drive(1'b1, 6'b111110, 4'd0, 4'd0, 4'd0);
    exp_q.push_back(e(5'b11110, 2'b11, 1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0));
    tick();
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    tick(); tick();

    // Illegal opcode
    chk("illegal_pre", 32'(illegal_op), 0);
    drive(1'b1, 6'b100001, 4'd1, 4'd1, 4'd1);
    peek();
    chk("illegal_in_ready", 32'(in_ready), 1);
    tick();
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    chk("illegal_bubble", 32'(out_valid), 0);
    chk("illegal_set", 32'(illegal_op), 1);
    tick(); tick();
    chk("illegal_sticky", 32'(illegal_op), 1);
`ifdef CU_PERF_CNT_EN
    chk("stall_count", 32'(stall_count), 2);
    chk("flush_count", 32'(flush_count), 2);
`endif

    rst_n = 1'b0;
    #1;
    chk("rst_clears_illegal", 32'(illegal_op), 0);
    chk("rst_clears_valid", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 6'b111111, 4'd2, 4'd2, 4'd2);
    tick();
    drive(1'b0, 6'b000000, 4'd0, 4'd0, 4'd0);
    chk("jump7_illegal", 32'(illegal_op), 1);
    chk("jump7_bubble", 32'(out_valid), 0);
    tick(); tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered, pipelined successor to the combinational opcode decoder. Sits between the fetch/decode (IF/ID) register and the execute stage, and acts as the ID/EX pipeline register for control signals.
- Decodes the 6-bit opcode, registers control plus register addresses behind a valid/ready handshake, detects load-use hazards, inserts bubbles, honours branch flushes and flags illegal opcodes.

Parameters:
- REG_W, 4, register-address width for rd/rs1/rs2.
- ALU_W, 5, width of alu_control. Must be >=5; extra upper bits are zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_ready  out  1  instruction is accepted this cycle.
- opcode  in  6  instruction opcode.
- rd, rs1, rs2  in  REG_W each  destination and source register addresses.
- flush  in  1  branch taken in EX; kill the instruction being decoded.
- out_ready  in  1  EX stage can accept.
- out_valid  out  1  EX register holds a real instruction.
- out_alu_control  out  ALU_W  ALU operation.
- out_imm_src  out  2  immediate format.
- out_pc_src, out_mem_to_reg, out_mem_write, out_reg_write, out_alu_src  out  1 each  datapath controls.
- out_rd, out_rs1, out_rs2  out  REG_W each  registered addresses.
- hazard_stall  out  1  combinational; load-use stall active this cycle.
- illegal_op  out  1  sticky; an illegal opcode was accepted.

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including out_valid and illegal_op. Outputs stay 0 until the first accepted instruction.
- Decode class is opcode[5:3]:
  - 000 R-arith, 001 I-arith, 010 R-logic, 011 I-logic, 101 memory, 111 jump. Classes 100 and 110 are illegal.
- Legal low bits:
  - Arith classes: 001..100 (ADD, SUB, MUL, MOV).
  - R-logic: 001..100 (AND, OR, XOR, NOT).
  - I-logic: 001..010 (ANDI, ORI).
  - Memory: 001..011 (LDR, LDA, STR).
  - Jump: 000..110 (JMP, JEQ, JNEQ, JGT, JGE, JLT, JLE).
  - Every other combination is illegal.
- alu_control = zero-extended {opcode[5:4], opcode[2:0]} (e.g. ANDI 011001 -> 01001).
- imm_src:
  - I-arith 00, I-logic 01, memory 10, jump 11.
  - R-type 00; don't-care is forbidden.
- alu_src = 1 for I-arith, I-logic, memory and jump; 0 otherwise.
- reg_write = 1 for all arith, logic, LDR and LDA; 0 for STR and jumps.
- mem_to_reg = 1 only for LDR.
- mem_write = 1 only for STR.
- pc_src = 1 only for the jump class.
- Source usage:
  - rs1 is used by R/I arith (except MOVI), R/I logic, LDR and STR.
  - rs2 is used by R-arith/R-logic except MOV and NOT, and by STR.
- advance = out_ready | ~out_valid.
- hazard = out_valid & out_mem_to_reg & in_valid & ((uses_rs1 & out_rd==rs1) | (uses_rs2 & out_rd==rs2)).
  - hazard_stall = hazard & ~flush.
- in_ready = flush | (advance & ~hazard).
- Per-edge update, in priority order:
  1. flush=1: EX register loads a bubble (out_valid=0, all controls 0) regardless of out_ready. Any input present is consumed and dropped.
  2. Otherwise, advance & hazard: load a bubble; input is held (in_ready=0).
  3. Otherwise, advance & in_valid & legal: load the decoded controls and addresses with out_valid=1. Latency is 1 cycle.
  4. Otherwise, advance & in_valid & illegal: load a bubble, consume the input, set illegal_op=1 (cleared only by reset).
  5. Otherwise, advance & ~in_valid: load a bubble.
  6. Otherwise (~advance): hold all outputs.
- Bubble fields: out_rd, out_rs1 and out_rs2 are cleared to 0.
- A held out_valid=1 entry never changes while out_ready=0, unless flush=1.
- Reset asserted mid-stall or mid-flush clears all state immediately; no pending instruction survives.

Optional Feature:
- Macro CU_PERF_CNT_EN.
- When defined, add two outputs, stall_count and flush_count, each 16 bits, reset 0:
  - stall_count increments on every cycle with hazard_stall=1.
  - flush_count increments on every cycle with flush=1 and in_valid=1.
  - Both saturate at 16'hFFFF.
- When undefined, the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD (000001, rd=3, rs1=1, rs2=2) with out_ready=1 -> next cycle out_valid=1, alu_control=00001, reg_write=1, alu_src=0, imm_src=00, out_rd=3.
- LDR rd=5 accepted, then SUB with rs2=5 -> hazard_stall=1 for 1 cycle, in_ready=0, one bubble. SUB appears one cycle later with alu_control=00010.
- STR (101011) -> mem_write=1, reg_write=0, alu_src=1, imm_src=10, pc_src=0.
- out_ready=0 holding ANDI; present ORI -> ANDI held, in_ready=0. Raise out_ready -> ORI (alu_control 01010, imm_src 01) loads next cycle.
- flush=1 with JEQ (111001) at input while out_ready=0 -> in_ready=1, out_valid=0 next cycle, JEQ never appears.
- opcode 100001 -> bubble, illegal_op=1 and stays 1 until rst_n=0. With CU_PERF_CNT_EN, counters match the injected stalls and flushes.
